// File: rtl/regfile_sweep.sv
// Parametrised integer register file: x0 reads zero, storage is cleared by a one-entry-per-cycle
// sweep after reset, and a per-register pending scoreboard flags in-flight producers. Option: REGFILE_BYPASS_EN.
module regfile_sweep #(
    parameter int XLEN = 32,
    parameter int AW   = 4
) (
    input  logic            I_clk,
    input  logic            I_rst,
    input  logic            I_regwen,
    input  logic [AW-1:0]   I_rd,
    input  logic [XLEN-1:0] I_data,
    input  logic [AW-1:0]   I_rs1,
    input  logic [AW-1:0]   I_rs2,
    input  logic            I_mark,
    input  logic [AW-1:0]   I_mark_rd,
    output logic [XLEN-1:0] O_data1,
    output logic [XLEN-1:0] O_data2,
    output logic            O_busy1,
    output logic            O_busy2,
    output logic            O_ready
);
    localparam int NREGS = 2 ** AW;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [NREGS-1:1] pend_q, pend_d;
    logic [NREGS-1:0] pend_full;
    logic            ready;
    logic            wr_ok;
    logic            mark_ok;

    assign ready   = (state_q == ST_READY);
    assign wr_ok   = ready && I_regwen && (I_rd != '0);
    assign mark_ok = ready && I_mark && (I_mark_rd != '0);
    assign O_ready = ready;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d = ST_READY;
            end
        end
    end

    // Single write port: the sweep owns it while clearing, the core owns it once ready.
    always_ff @(posedge I_clk) begin
        if (!I_rst) begin
            if (state_q == ST_CLEAR) begin
                regs_q[cnt_q] <= '0;
            end else if (wr_ok) begin
                regs_q[I_rd] <= I_data;
            end
        end
    end

    // A mark names the newest producer, so it overrides a same-cycle write clearing the bit.
    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_pend
            assign pend_d[gi] = (mark_ok && (I_mark_rd == AW'(gi))) ? 1'b1 :
                                (wr_ok && (I_rd == AW'(gi)))        ? 1'b0 :
                                pend_q[gi];
        end
    endgenerate

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_full = {pend_q, 1'b0};

    always_comb begin
        O_data1 = '0;
        O_data2 = '0;
        O_busy1 = 1'b0;
        O_busy2 = 1'b0;
        if (ready && (I_rs1 != '0)) begin
            O_data1 = regs_q[I_rs1];
            O_busy1 = pend_full[I_rs1];
        end
        if (ready && (I_rs2 != '0)) begin
            O_data2 = regs_q[I_rs2];
            O_busy2 = pend_full[I_rs2];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (I_rs1 == I_rd)) begin
            O_data1 = I_data;
            if (!(mark_ok && (I_mark_rd == I_rd))) begin
                O_busy1 = 1'b0;
            end
        end
        if (wr_ok && (I_rs2 == I_rd)) begin
            O_data2 = I_data;
            if (!(mark_ok && (I_mark_rd == I_rd))) begin
                O_busy2 = 1'b0;
            end
        end
`endif
    end
endmodule

// File: tb/tb_regfile_sweep.sv
// Self-checking bench for regfile_sweep: a 16x32 instance for most scenarios and a 32x64 instance
// for the wide sweep. Expected values are queued at stimulus time and popped at comparison time.
module tb_regfile_sweep;
    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        a_rst, a_regwen, a_mark;
    logic [3:0]  a_rd, a_rs1, a_rs2, a_mark_rd;
    logic [31:0] a_data, a_data1, a_data2;
    logic        a_busy1, a_busy2, a_ready;

    logic        b_rst, b_regwen, b_mark;
    logic [4:0]  b_rd, b_rs1, b_rs2, b_mark_rd;
    logic [63:0] b_data, b_data1, b_data2;
    logic        b_busy1, b_busy2, b_ready;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;

    regfile_sweep #(.XLEN(32), .AW(4)) dut_a (
        .I_clk(clk), .I_rst(a_rst), .I_regwen(a_regwen), .I_rd(a_rd), .I_data(a_data),
        .I_rs1(a_rs1), .I_rs2(a_rs2), .I_mark(a_mark), .I_mark_rd(a_mark_rd),
        .O_data1(a_data1), .O_data2(a_data2), .O_busy1(a_busy1), .O_busy2(a_busy2),
        .O_ready(a_ready)
    );

    regfile_sweep #(.XLEN(64), .AW(5)) dut_b (
        .I_clk(clk), .I_rst(b_rst), .I_regwen(b_regwen), .I_rd(b_rd), .I_data(b_data),
        .I_rs1(b_rs1), .I_rs2(b_rs2), .I_mark(b_mark), .I_mark_rd(b_mark_rd),
        .O_data1(b_data1), .O_data2(b_data2), .O_busy1(b_busy1), .O_busy2(b_busy2),
        .O_ready(b_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        a_regwen = 1'b0; a_mark = 1'b0; a_rd = '0; a_data = '0; a_rs1 = 4'd5; a_rs2 = 4'd5; a_mark_rd = '0;
        b_regwen = 1'b0; b_mark = 1'b0; b_rd = '0; b_data = '0; b_rs1 = '0; b_rs2 = '0; b_mark_rd = '0;
        for (int i = 0; i < 3; i++) step();
        exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        e = exp_q.pop_front(); total++;
        if (64'(a_ready) !== e) begin bad++; $display("FAIL reset_ready got=%h exp=%h", a_ready, e); end
        else $display("ok reset_ready=%h", a_ready);
        e = exp_q.pop_front(); total++;
        if (64'(a_data1) !== e) begin bad++; $display("FAIL reset_data1 got=%h exp=%h", a_data1, e); end
        else $display("ok reset_data1=%h", a_data1);
        e = exp_q.pop_front(); total++;
        if (64'({a_busy1, a_busy2}) !== e) begin bad++; $display("FAIL reset_busy got=%b%b exp=%h", a_busy1, a_busy2, e); end
        else $display("ok reset_busy=%b%b", a_busy1, a_busy2);
    endtask

    task automatic test_sweep();
        a_rst = 1'b0;
        for (int ed = 1; ed <= 15; ed++) begin
            step();
            exp_q.push_back((ed == 15) ? 64'd1 : 64'd0);
            e = exp_q.pop_front(); total++;
            if (64'(a_ready) !== e) begin bad++; $display("FAIL sweep_ready_edge%0d got=%h exp=%h", ed, a_ready, e); end
            else $display("ok sweep edge %0d ready=%h", ed, a_ready);
            if (ed == 9) begin a_regwen = 1'b1; a_rd = 4'd5; a_data = 32'hDEADBEEF; end
            if (ed == 10) a_regwen = 1'b0;
        end
        a_rs1 = 4'd5; a_rs2 = 4'd5;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); total++;
        if (64'(a_data1) !== e) begin bad++; $display("FAIL sweep_drop_x5_p1 got=%h exp=%h", a_data1, e); end
        else $display("ok x5 port1=%h", a_data1);
        e = exp_q.pop_front(); total++;
        if (64'(a_data2) !== e) begin bad++; $display("FAIL sweep_drop_x5_p2 got=%h exp=%h", a_data2, e); end
        else $display("ok x5 port2=%h", a_data2);
    endtask

    task automatic test_basic();
        a_regwen = 1'b1; a_rd = 4'd7; a_data = 32'h12345678;
        exp_q.push_back(64'h12345678); exp_q.push_back(64'h12345678);
        step();
        a_regwen = 1'b0; a_rs1 = 4'd7; a_rs2 = 4'd7;
        #1;
        e = exp_q.pop_front(); total++;
        if (64'(a_data1) !== e) begin bad++; $display("FAIL basic_x7_p1 got=%h exp=%h", a_data1, e); end
        else $display("ok write x7 read port1=%h", a_data1);
        e = exp_q.pop_front(); total++;
        if (64'(a_data2) !== e) begin bad++; $display("FAIL basic_x7_p2 got=%h exp=%h", a_data2, e); end
        else $display("ok write x7 read port2=%h", a_data2);
        a_regwen = 1'b1; a_rd = 4'd0; a_data = 32'hFFFFFFFF;
        exp_q.push_back(64'd0);
        step();
        a_regwen = 1'b0; a_rs1 = 4'd0;
        #1;
        e = exp_q.pop_front(); total++;
        if (64'(a_data1) !== e) begin bad++; $display("FAIL basic_x0 got=%h exp=%h", a_data1, e); end
        else $display("ok write x0 read=%h", a_data1);
    endtask

    task automatic test_bypass();
        a_regwen = 1'b1; a_rd = 4'd3; a_data = 32'h11111111;
        step();
        a_data = 32'hA5A5A5A5; a_rs1 = 4'd3; a_rs2 = 4'd7;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(64'hA5A5A5A5);
`else
        exp_q.push_back(64'h11111111);
`endif
        exp_q.push_back(64'h12345678);
        exp_q.push_back(64'hA5A5A5A5);
        #1;
        e = exp_q.pop_front(); total++;
        if (64'(a_data1) !== e) begin bad++; $display("FAIL bypass_same_cycle got=%h exp=%h", a_data1, e); end
        else $display("ok same-cycle x3=%h", a_data1);
        e = exp_q.pop_front(); total++;
        if (64'(a_data2) !== e) begin bad++; $display("FAIL bypass_other_port got=%h exp=%h", a_data2, e); end
        else $display("ok other port x7=%h", a_data2);
        step();
        a_regwen = 1'b0;
        #1;
        e = exp_q.pop_front(); total++;
        if (64'(a_data1) !== e) begin bad++; $display("FAIL bypass_next_cycle got=%h exp=%h", a_data1, e); end
        else $display("ok next-cycle x3=%h", a_data1);
    endtask

    task automatic test_scoreboard();
        a_mark = 1'b1; a_mark_rd = 4'd9; a_rs1 = 4'd9; a_rs2 = 4'd0;
        exp_q.push_back(64'd0); exp_q.push_back(64'd1);
        #1;
        e = exp_q.pop_front(); total++;
        if (64'(a_busy1) !== e) begin bad++; $display("FAIL sb_before_mark got=%h exp=%h", a_busy1, e); end
        else $display("ok busy before mark=%h", a_busy1);
        step();
        a_mark = 1'b0;
        #1;
        e = exp_q.pop_front(); total++;
        if (64'(a_busy1) !== e) begin bad++; $display("FAIL sb_marked got=%h exp=%h", a_busy1, e); end
        else $display("ok busy after mark=%h", a_busy1);
        step();
        a_regwen = 1'b1; a_rd = 4'd9; a_data = 32'h00000099;
        exp_q.push_back(64'd0); exp_q.push_back(64'h99);
        step();
        a_regwen = 1'b0;
        #1;
        e = exp_q.pop_front(); total++;
        if (64'(a_busy1) !== e) begin bad++; $display("FAIL sb_cleared got=%h exp=%h", a_busy1, e); end
        else $display("ok busy after write=%h", a_busy1);
        e = exp_q.pop_front(); total++;
        if (64'(a_data1) !== e) begin bad++; $display("FAIL sb_x9_data got=%h exp=%h", a_data1, e); end
        else $display("ok x9 data=%h", a_data1);
        a_mark = 1'b1; a_mark_rd = 4'd9; a_regwen = 1'b1; a_rd = 4'd9; a_data = 32'h00000077;
        exp_q.push_back(64'd1); exp_q.push_back(64'd0);
        step();
        a_mark = 1'b0; a_regwen = 1'b0;
        #1;
        e = exp_q.pop_front(); total++;
        if (64'(a_busy1) !== e) begin bad++; $display("FAIL sb_mark_wins got=%h exp=%h", a_busy1, e); end
        else $display("ok mark+write busy=%h", a_busy1);
        e = exp_q.pop_front(); total++;
        if (64'(a_busy2) !== e) begin bad++; $display("FAIL sb_x0_busy got=%h exp=%h", a_busy2, e); end
        else $display("ok x0 busy=%h", a_busy2);
    endtask

    task automatic test_midreset();
        for (int r = 1; r < 16; r++) begin
            a_regwen = 1'b1; a_rd = 4'(r); a_data = 32'h10000000 + 32'(r);
            step();
        end
        a_regwen = 1'b0; a_mark = 1'b1; a_mark_rd = 4'd4;
        step();
        a_mark = 1'b0; a_rs1 = 4'd4;
        exp_q.push_back(64'd1); exp_q.push_back(64'h10000004);
        #1;
        e = exp_q.pop_front(); total++;
        if (64'(a_busy1) !== e) begin bad++; $display("FAIL mid_pre_busy got=%h exp=%h", a_busy1, e); end
        else $display("ok x4 busy before reset=%h", a_busy1);
        e = exp_q.pop_front(); total++;
        if (64'(a_data1) !== e) begin bad++; $display("FAIL mid_pre_data got=%h exp=%h", a_data1, e); end
        else $display("ok x4 data before reset=%h", a_data1);
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        for (int r = 0; r < 16; r++) begin
            a_rs1 = 4'(r); a_rs2 = 4'(r);
            exp_q.push_back({32'd0, 32'd0}); exp_q.push_back({62'd0, 2'b00});
            #1;
            e = exp_q.pop_front(); total++;
            if ({a_data1, a_data2} !== e) begin bad++; $display("FAIL mid_data_x%0d got=%h_%h exp=%h", r, a_data1, a_data2, e); end
            else $display("ok post-reset x%0d data=%h", r, a_data1);
            e = exp_q.pop_front(); total++;
            if (64'({a_busy1, a_busy2}) !== e) begin bad++; $display("FAIL mid_busy_x%0d got=%b%b exp=%h", r, a_busy1, a_busy2, e); end
            else $display("ok post-reset x%0d busy=%b%b", r, a_busy1, a_busy2);
        end
        exp_q.push_back(64'd0);
        e = exp_q.pop_front(); total++;
        if (64'(a_ready) !== e) begin bad++; $display("FAIL mid_ready_low got=%h exp=%h", a_ready, e); end
        else $display("ok post-reset ready=%h", a_ready);
        for (int ed = 1; ed <= 15; ed++) step();
        exp_q.push_back(64'd1);
        e = exp_q.pop_front(); total++;
        if (64'(a_ready) !== e) begin bad++; $display("FAIL mid_ready_15 got=%h exp=%h", a_ready, e); end
        else $display("ok resweep ready=%h", a_ready);
        for (int r = 1; r < 16; r++) begin
            a_rs1 = 4'(r);
            exp_q.push_back(64'd0);
            #1;
            e = exp_q.pop_front(); total++;
            if (64'(a_data1) !== e) begin bad++; $display("FAIL mid_cleared_x%0d got=%h exp=%h", r, a_data1, e); end
            else $display("ok cleared x%0d=%h", r, a_data1);
        end
    endtask

    task automatic test_wide();
        step();
        b_rst = 1'b0;
        for (int ed = 1; ed <= 31; ed++) begin
            step();
            if (ed >= 30) begin
                exp_q.push_back((ed == 31) ? 64'd1 : 64'd0);
                e = exp_q.pop_front(); total++;
                if (64'(b_ready) !== e) begin bad++; $display("FAIL wide_ready_edge%0d got=%h exp=%h", ed, b_ready, e); end
                else $display("ok wide edge %0d ready=%h", ed, b_ready);
            end
        end
        b_regwen = 1'b1; b_rd = 5'd31; b_data = 64'h0123456789ABCDEF;
        exp_q.push_back(64'h0123456789ABCDEF); exp_q.push_back(64'h0123456789ABCDEF);
        step();
        b_regwen = 1'b0; b_rs1 = 5'd31; b_rs2 = 5'd31;
        #1;
        e = exp_q.pop_front(); total++;
        if (b_data1 !== e) begin bad++; $display("FAIL wide_x31_p1 got=%h exp=%h", b_data1, e); end
        else $display("ok wide x31 port1=%h", b_data1);
        e = exp_q.pop_front(); total++;
        if (b_data2 !== e) begin bad++; $display("FAIL wide_x31_p2 got=%h exp=%h", b_data2, e); end
        else $display("ok wide x31 port2=%h", b_data2);
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_basic();
        test_bypass();
        test_scoreboard();
        test_midreset();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
